// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard sequencer: drives PC and pipeline-register enables/flushes for a 5-stage MIPS core.
// Latency: outputs are combinational from registered state plus inputs; effects land at the next edge.
// Backpressure: memory wait stalls everything up to EX/MEM; mul/div stalls up to ID/EX; load-use inserts one bubble.
module hazard_stall_ctrl #(
  parameter int MD_LATENCY  = 4,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rt,
  input  logic        idex_md_start,
  input  logic        branch_taken,
  input  logic [1:0]  exmem_mem,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        md_done,
  output logic        mem_err,
  output logic [15:0] stall_cycles
);

  typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} state_t;

  // First EX cycle is spent in RUN, the release cycle at md_cnt == 0, hence the -2.
  localparam logic [3:0] MD_RELOAD  = 4'(MD_LATENCY - 2);
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [3:0] md_cnt, md_cnt_nxt;
  logic [7:0] wait_cnt;

  logic mem_stall;
  logic md_stall;
  logic lu_hazard;

  // Hazard detection from current inputs and state.
  always_comb begin
    mem_stall = (exmem_mem != 2'b00) && !dmem_ready;
    md_stall  = ((state == RUN) && idex_md_start) ||
                ((state == MD_BUSY) && (md_cnt != 4'd0));
    lu_hazard = idex_memread && (idex_rt != 5'd0) &&
                ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
  end

  // Prioritised enable/flush generation; reset forces everything inactive.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    md_done     = 1'b0;
    if (rst) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else begin
      md_done = (state == MD_BUSY) && (md_cnt == 4'd0) && !mem_stall;
      if (mem_stall) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_flush = 1'b1;
      end else if (md_stall) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_flush = 1'b1;
      end else if (branch_taken) begin
        // The branch squashes the dependent instruction, so load-use is moot.
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (lu_hazard) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  // Mul/div occupancy next-state: the unit counts down even while memory stalls.
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    case (state)
      RUN: begin
        if (idex_md_start && !mem_stall) begin
          md_cnt_nxt = MD_RELOAD;
          state_nxt  = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (md_cnt != 4'd0) begin
          md_cnt_nxt = md_cnt - 4'd1;
        end else if (!mem_stall) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      md_cnt <= 4'd0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // Memory wait tracking with sticky timeout flag; the access itself is never aborted.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else if (mem_stall) begin
      if (wait_cnt != 8'hFF) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (wait_cnt == WAIT_LIMIT) begin
        mem_err <= 1'b1;
      end
    end else begin
      wait_cnt <= 8'd0;
    end
  end

  // Saturating debug count of cycles where the PC did not advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 16'd0;
    end else if (!pc_en && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with MD_LATENCY=4, MEM_TIMEOUT=8.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
// Expected values are hand-computed constants.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ifid_rs, ifid_rt, idex_rt;
  logic        idex_memread, idex_md_start, branch_taken, dmem_ready;
  logic [1:0]  exmem_mem;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic        md_done, mem_err;
  logic [15:0] stall_cycles;

  int tests  = 0;
  int errors = 0;

  // Output vector order: pc,ifid,idex,exmem,memwb en | ifid,idex,exmem,memwb flush | md_done
  localparam logic [9:0] V_RST  = 10'b00000_0000_0;
  localparam logic [9:0] V_NORM = 10'b11111_0000_0;
  localparam logic [9:0] V_LU   = 10'b00111_0100_0;
  localparam logic [9:0] V_MD   = 10'b00011_0010_0;
  localparam logic [9:0] V_DONE = 10'b11111_0000_1;
  localparam logic [9:0] V_MEM  = 10'b00001_0001_0;
  localparam logic [9:0] V_BR   = 10'b11111_1100_0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MD_LATENCY(4), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt), .idex_md_start(idex_md_start),
    .branch_taken(branch_taken), .exmem_mem(exmem_mem), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush), .md_done(md_done), .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  wire [9:0] outv = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                     ifid_flush, idex_flush, exmem_flush, memwb_flush, md_done};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifid_rs = 5'd0; ifid_rt = 5'd0; idex_rt = 5'd0;
    idex_memread = 1'b0; idex_md_start = 1'b0; branch_taken = 1'b0;
    exmem_mem = 2'b00; dmem_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    check("rst_outputs", 32'(outv), 32'(V_RST));
    tick(); tick();
    rst = 1'b0;
    #1;
    check("post_rst_outputs", 32'(outv), 32'(V_NORM));
    check("post_rst_stall_cnt", 32'(stall_cycles), 32'd0);
    check("post_rst_mem_err", 32'(mem_err), 32'd0);

    // Load-use on rs
    tick();
    idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    #1 check("lu_rs", 32'(outv), 32'(V_LU));
    tick();
    idle_inputs();
    #1 check("lu_after", 32'(outv), 32'(V_NORM));
    check("lu_stall_cnt", 32'(stall_cycles), 32'd1);

    // Load to r0 never stalls
    idex_memread = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    #1 check("lu_r0", 32'(outv), 32'(V_NORM));
    // Load-use on rt
    tick();
    idex_memread = 1'b1; idex_rt = 5'd7; ifid_rs = 5'd3; ifid_rt = 5'd7;
    #1 check("lu_rt", 32'(outv), 32'(V_LU));
    // Non-load with matching register does not stall
    idex_memread = 1'b0;
    #1 check("no_load_match", 32'(outv), 32'(V_NORM));
    idex_memread = 1'b1;
    tick();
    idle_inputs();
    #1 check("lu_rt_stall_cnt", 32'(stall_cycles), 32'd2);

    // Mul/div: three stall cycles then a release pulse
    idex_md_start = 1'b1;
    #1 check("md_c0", 32'(outv), 32'(V_MD));
    tick(); check("md_c1", 32'(outv), 32'(V_MD));
    tick(); check("md_c2", 32'(outv), 32'(V_MD));
    tick(); check("md_release", 32'(outv), 32'(V_DONE));
    tick();
    idex_md_start = 1'b0;
    #1 check("md_back_to_run", 32'(outv), 32'(V_NORM));
    check("md_stall_cnt", 32'(stall_cycles), 32'd5);

    // Memory wait: 5 stall cycles then completion
    exmem_mem = 2'b10; dmem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 check($sformatf("memwait_c%0d", i), 32'(outv), 32'(V_MEM));
      tick();
    end
    dmem_ready = 1'b1;
    #1 check("memwait_done", 32'(outv), 32'(V_NORM));
    check("memwait_no_err", 32'(mem_err), 32'd0);
    tick();
    idle_inputs();
    #1 check("memwait_stall_cnt", 32'(stall_cycles), 32'd10);

    // Timeout: flag sets at the edge ending the 8th stall cycle
    exmem_mem = 2'b01; dmem_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1 check($sformatf("timeout_err_c%0d", i), 32'(mem_err), (i >= 8) ? 32'd1 : 32'd0);
      tick();
    end
    dmem_ready = 1'b1;
    #1 check("timeout_sticky", 32'(mem_err), 32'd1);
    check("timeout_outputs", 32'(outv), 32'(V_NORM));
    tick();
    idle_inputs();
    #1 check("timeout_stall_cnt", 32'(stall_cycles), 32'd20);

    // Branch beats load-use
    branch_taken = 1'b1; idex_memread = 1'b1; idex_rt = 5'd3; ifid_rs = 5'd3;
    #1 check("branch_over_lu", 32'(outv), 32'(V_BR));
    tick();
    idle_inputs();
    #1 check("branch_no_stall", 32'(stall_cycles), 32'd20);

    // Memory stall at the MD release cycle defers md_done
    idex_md_start = 1'b1; dmem_ready = 1'b1;
    #1 check("mdmem_c0", 32'(outv), 32'(V_MD));
    tick(); tick();
    #1 check("mdmem_c2", 32'(outv), 32'(V_MD));
    tick();
    exmem_mem = 2'b10; dmem_ready = 1'b0;
    #1 check("mdmem_deferred0", 32'(outv), 32'(V_MEM));
    tick();
    #1 check("mdmem_deferred1", 32'(outv), 32'(V_MEM));
    tick();
    dmem_ready = 1'b1;
    #1 check("mdmem_release", 32'(outv), 32'(V_DONE));
    tick();
    idle_inputs();
    #1 check("mdmem_run", 32'(outv), 32'(V_NORM));
    check("mdmem_stall_cnt", 32'(stall_cycles), 32'd25);

    // Reset on the 2nd MD_BUSY cycle
    idex_md_start = 1'b1;
    tick(); tick();
    rst = 1'b1;
    #1 check("rstmd_outputs", 32'(outv), 32'(V_RST));
    tick();
    rst = 1'b0; idex_md_start = 1'b0;
    #1 check("rstmd_run", 32'(outv), 32'(V_NORM));
    check("rstmd_stall_cnt", 32'(stall_cycles), 32'd0);
    check("rstmd_mem_err", 32'(mem_err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rstmd_quiet_c%0d", i), 32'(outv), 32'(V_NORM));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central sequencer for the 5-stage MIPS pipeline.
- Drives the enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves four hazard sources: data-memory wait states, multi-cycle mul/div occupancy of EX, taken branches resolved in EX, and load-use hazards.
- Keeps a memory-timeout error flag and a saturating stall-cycle counter for debug.

Parameters:
- MD_LATENCY, 4: total cycles a mul/div instruction occupies EX; legal range 2..15.
- MEM_TIMEOUT, 64: consecutive MEM wait cycles before mem_err sets; legal range 2..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- ifid_rs  in  5  rs field of the instruction in IF/ID.
- ifid_rt  in  5  rt field of the instruction in IF/ID.
- idex_memread  in  1  MemRead control bit of the instruction in ID/EX.
- idex_rt  in  5  destination rt of the instruction in ID/EX.
- idex_md_start  in  1  the instruction in ID/EX (now executing in EX) is mul/div.
- branch_taken  in  1  taken branch/jump resolved in EX this cycle.
- exmem_mem  in  2  EX/MEM MEM control field: bit1 = MemRead, bit0 = MemWrite.
- dmem_ready  in  1  data memory completes the current access this cycle.
- pc_en  out  1  PC load enable.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  the register loads a bubble (all control fields zero) this edge; only meaningful with the matching _en = 1.
- md_done  out  1  one-cycle pulse on the mul/div release cycle.
- mem_err  out  1  sticky memory timeout flag.
- stall_cycles  out  16  count of cycles with pc_en = 0, saturating at 16'hFFFF.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - While rst = 1: every _en = 0, every _flush = 0, md_done = 0.
  - At the rst edge: state <= RUN, md_cnt <= 0, wait_cnt <= 0, mem_err <= 0, stall_cycles <= 0.
  - Reset mid-operation aborts any MEM_WAIT or MD_BUSY immediately.
- States: RUN, MD_BUSY. Internal counters: md_cnt (4 bits), wait_cnt (8 bits).
- Stall sources, all combinational on current inputs and state:
  - mem_stall = (exmem_mem != 0) & ~dmem_ready
  - md_stall = (state == RUN & idex_md_start) | (state == MD_BUSY & md_cnt != 0)
  - lu_hazard = idex_memread & (idex_rt != 0) & (idex_rt == ifid_rs | idex_rt == ifid_rt)
- Output priority, first match wins; any signal not listed is en = 1, flush = 0:
  1. mem_stall: pc_en, ifid_en, idex_en, exmem_en = 0; memwb_en = 1 with memwb_flush = 1.
  2. md_stall: pc_en, ifid_en, idex_en = 0; exmem_en = 1 with exmem_flush = 1.
  3. branch_taken: pc_en = 1 (PC loads the target); ifid_flush = 1; idex_flush = 1.
  4. lu_hazard: pc_en, ifid_en = 0; idex_flush = 1. Exactly one bubble per load-use pair.
- Branch vs load-use: when both are true, the branch wins. The dependent instruction is squashed anyway.
- MD sequencing:
  - In RUN with idex_md_start and no mem_stall: md_cnt <= MD_LATENCY-2, state <= MD_BUSY.
  - In MD_BUSY: md_cnt decrements each cycle while nonzero, including during mem_stall, because the unit runs independently.
  - In MD_BUSY with md_cnt == 0 and no mem_stall: this is the release cycle. Pipeline advances, md_done = 1, state <= RUN.
  - In MD_BUSY with md_cnt == 0 and mem_stall: hold in MD_BUSY with md_done = 0; release on the first cycle without mem_stall.
  - Net effect: pc_en is low for exactly MD_LATENCY-1 cycles when no memory stall overlaps.
  - idex_md_start is ignored while in MD_BUSY.
- Memory timeout:
  - wait_cnt increments each mem_stall cycle, saturating, and clears on any cycle without mem_stall.
  - When wait_cnt reaches MEM_TIMEOUT-1 during a mem_stall cycle, mem_err <= 1. It stays set until rst.
  - The stall continues regardless of mem_err; the block never aborts the access.
- stall_cycles increments on every non-reset cycle with pc_en = 0 and holds at 16'hFFFF.
- Outputs are combinational from registered state plus inputs. The block adds no latency; effects apply at the next edge of the target register.

Test Plan:
- Load-use: lw in ID/EX with idex_rt = 5, ifid_rs = 5 -> one cycle of pc_en = 0, ifid_en = 0, idex_flush = 1; next cycle all en = 1, stall_cycles = 1. Repeat with idex_rt = 0 -> no stall.
- Mul/div with MD_LATENCY = 4: idex_md_start pulse -> pc_en low 3 cycles with exmem_flush = 1 each; md_done high on the 4th cycle; state returns to RUN; stall_cycles = 3.
- Memory wait: exmem_mem = 2'b10, dmem_ready low 5 cycles then high -> pc/ifid/idex/exmem_en = 0 and memwb_flush = 1 for 5 cycles, normal on the 6th; mem_err = 0.
- Timeout with MEM_TIMEOUT = 8: dmem_ready held low 10 cycles -> mem_err rises at the edge ending the 8th stall cycle; stays 1 after dmem_ready; cleared only by rst.
- Priority: branch_taken and lu_hazard together -> ifid_flush = idex_flush = 1, pc_en = 1. mem_stall during MD_BUSY with md_cnt = 0 -> mem response wins, md_done deferred until dmem_ready = 1.
- Reset mid-MD: assert rst on the 2nd MD_BUSY cycle -> all outputs 0 during rst; after release state is RUN, pc_en = 1, md_done never pulses, stall_cycles = 0.
